// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an attached LFSR by seeding it and counting cycles until the seed reappears.
// Latency: done pulses E(P+2) after the accepting edge E0 for a period-P match, E2 on lock-up, E(MAX_CYCLES+2) on timeout.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while a measurement is in flight.
module lfsr_period_checker #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 5,
  parameter int EXP_PERIOD = 15,
  parameter int MAX_CYCLES = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] seed,
  output logic             sel,
  input  logic [WIDTH-1:0] state,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             pass,
  output logic             lockup,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LP_MAX_CYC = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LP_EXP_PER = CNT_W'(EXP_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_seed;
  logic [CNT_W-1:0] r_period;
  logic             r_pass;
  logic             r_lockup;
  logic             r_timeout;

  // Per-cycle events decoded from the FSM; they steer the datapath registers.
  logic             w_accept;
  logic             w_lock;
  logic             w_match;
  logic             w_tmo;

  // State register; reset aborts any measurement without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and decoded outputs. RUN checks are prioritised lock-up, match, timeout.
  always_comb begin
    w_fsm_nxt = r_fsm;
    sel       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    w_accept  = 1'b0;
    w_lock    = 1'b0;
    w_match   = 1'b0;
    w_tmo     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // LFSR picks up the seed on the edge that leaves this state.
        sel       = 1'b1;
        busy      = 1'b1;
        w_fsm_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (state == '0) begin
          w_lock    = 1'b1;
          w_fsm_nxt = S_DONE;
        end else if ((r_cnt != '0) && (state == r_seed)) begin
          // At count 0 the state is the freshly loaded seed, not a recurrence.
          w_match   = 1'b1;
          w_fsm_nxt = S_DONE;
        end else if (r_cnt == LP_MAX_CYC) begin
          w_tmo     = 1'b1;
          w_fsm_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        w_fsm_nxt = S_IDLE;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  // Cycle counter: cleared on leaving LOAD, advanced only when no RUN check fired, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_fsm == S_LOAD) begin
      r_cnt <= '0;
    end else if ((r_fsm == S_RUN) && !w_lock && !w_match && !w_tmo) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Seed capture and result registers; results hold until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed    <= '0;
      r_period  <= '0;
      r_pass    <= 1'b0;
      r_lockup  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_seed    <= seed_in;
      r_period  <= '0;
      r_pass    <= 1'b0;
      r_lockup  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_lock) begin
      r_lockup  <= 1'b1;
      r_period  <= '0;
    end else if (w_match) begin
      r_period  <= r_cnt;
      r_pass    <= (r_cnt == LP_EXP_PER);
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
      r_period  <= '0;
    end
  end

  assign seed    = r_seed;
  assign period  = r_period;
  assign pass    = r_pass;
  assign lockup  = r_lockup;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker driving a maximal-length 4-bit LFSR (x^4+x^3+1).
// Latency: expected done edges are hand-derived from the E0 numbering.
// Backpressure: not applicable; start glitches exercise the ignore-while-busy path.
module tb_lfsr_period_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] seed_in;
  logic [3:0] seed;
  logic       sel;
  logic [3:0] w_state;
  logic       busy;
  logic       done;
  logic [4:0] period;
  logic       pass;
  logic       lockup;
  logic       timeout;

  logic [3:0] r_lfsr;
  logic       detach;

  int total;
  int bad;

  lfsr_period_checker #(
    .WIDTH(4), .CNT_W(5), .EXP_PERIOD(15), .MAX_CYCLES(31)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .seed(seed), .sel(sel), .state(w_state), .busy(busy), .done(done),
    .period(period), .pass(pass), .lockup(lockup), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: load on sel, otherwise Fibonacci shift with taps 4,3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 4'b0000;
    else if (sel) r_lfsr <= seed;
    else r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  assign w_state = detach ? 4'b0101 : r_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch a measurement; returns the edge index (E0 = accept) after which done was seen, -1 if never.
  // glitch_edge > 0 holds start high (with a different seed) across that edge.
  task automatic measure(input logic [3:0] s, input int glitch_edge,
                         output int done_edge, output logic sel_e0, output logic sel_e1);
    start   = 1'b1;
    seed_in = s;
    @(posedge clk); #1;
    start  = 1'b0;
    sel_e0 = sel;
    sel_e1 = 1'b1;
    done_edge = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == glitch_edge) begin
        start   = 1'b1;
        seed_in = 4'b0000;
      end
      @(posedge clk); #1;
      start   = 1'b0;
      seed_in = s;
      if (n == 1) sel_e1 = sel;
      if (done) begin
        done_edge = n;
        break;
      end
    end
  endtask

  int   de;
  logic s0;
  logic s1;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    seed_in = 4'b0000;
    detach  = 1'b0;
    #1;
    check("rst_seed",    32'(seed),    0);
    check("rst_sel",     32'(sel),     0);
    check("rst_busy",    32'(busy),    0);
    check("rst_done",    32'(done),    0);
    check("rst_period",  32'(period),  0);
    check("rst_pass",    32'(pass),    0);
    check("rst_lockup",  32'(lockup),  0);
    check("rst_timeout", 32'(timeout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Seed 1111 on the live LFSR: full period.
    measure(4'b1111, 0, de, s0, s1);
    check("f_sel_e0",  32'(s0), 1);
    check("f_sel_e1",  32'(s1), 0);
    check("f_done_at", 32'(de), 17);
    check("f_period",  32'(period), 15);
    check("f_pass",    32'(pass), 1);
    check("f_lockup",  32'(lockup), 0);
    check("f_timeout", 32'(timeout), 0);
    check("f_busy",    32'(busy), 0);
    @(posedge clk); #1;
    check("f_done_pulse", 32'(done), 0);

    // Back-to-back 1010 then 1001, with hold check in between.
    measure(4'b1010, 0, de, s0, s1);
    check("a_done_at", 32'(de), 17);
    check("a_period",  32'(period), 15);
    check("a_pass",    32'(pass), 1);
    repeat (3) @(posedge clk); #1;
    check("a_hold_period", 32'(period), 15);
    check("a_hold_pass",   32'(pass), 1);
    measure(4'b1001, 0, de, s0, s1);
    check("9_done_at", 32'(de), 17);
    check("9_period",  32'(period), 15);
    check("9_pass",    32'(pass), 1);
    @(posedge clk); #1;

    // Seed 0000 locks the LFSR.
    measure(4'b0000, 0, de, s0, s1);
    check("z_done_at", 32'(de), 2);
    check("z_lockup",  32'(lockup), 1);
    check("z_period",  32'(period), 0);
    check("z_pass",    32'(pass), 0);
    check("z_timeout", 32'(timeout), 0);
    @(posedge clk); #1;

    // Detached LFSR, constant 0101: never recurs.
    detach = 1'b1;
    measure(4'b1111, 0, de, s0, s1);
    check("t_done_at", 32'(de), 33);
    check("t_timeout", 32'(timeout), 1);
    check("t_period",  32'(period), 0);
    check("t_pass",    32'(pass), 0);
    check("t_lockup",  32'(lockup), 0);
    detach = 1'b0;
    @(posedge clk); #1;

    // Start re-pulsed mid-run with a different seed must be ignored.
    measure(4'b1111, 6, de, s0, s1);
    check("g_done_at", 32'(de), 17);
    check("g_seed",    32'(seed), 15);
    check("g_period",  32'(period), 15);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts without done.
    start   = 1'b1;
    seed_in = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("r_busy",   32'(busy), 0);
    check("r_sel",    32'(sel), 0);
    check("r_done",   32'(done), 0);
    check("r_seed",   32'(seed), 0);
    check("r_period", 32'(period), 0);
    @(posedge clk); #1;
    check("r_done_held", 32'(done), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    measure(4'b1111, 0, de, s0, s1);
    check("p_done_at", 32'(de), 17);
    check("p_period",  32'(period), 15);
    check("p_pass",    32'(pass), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
